qpd_sweep_ctrl: RTL and testbench

//  Sequencer for the quarter-period-delay trigger generator (QPD). Steps the delay back and forth

---
 rtl/qpd_sweep_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_qpd_sweep_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/qpd_sweep_ctrl.sv
// qpd_sweep_ctrl: sweeps the QPD delay between shadowed min/max bounds, one trigger per point per leg.
// Optional QPD_SWEEP_DWELL_EN repeats each point max(dwell,1) times before stepping.
module qpd_sweep_ctrl #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       sclock,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] delay_min,
  input  logic [7:0] delay_max,
  input  logic [7:0] delay_step,
  input  logic [7:0] n_passes,
  input  logic [3:0] dwell,
  input  logic       trigger_in,
  output logic       rt,
  output logic [7:0] count_quater_period,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] pass_count,
  output logic       dir
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, SETTLE, STEP, DONE, ERROR} state_t;
  state_t state_q, state_d;
  logic [7:0] min_q, min_d, max_q, max_d, step_q, step_d, npass_q, npass_d;
  logic [7:0] cur_q, cur_d, cqp_q, cqp_d, pass_q, pass_d;
  logic dir_q, dir_d, trig_q, trig_prev_q, trig_edge, at_end;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [SW-1:0] set_q, set_d;
  logic [8:0] sum9, lo9;
  logic [7:0] asc_nxt, desc_nxt;
`ifdef QPD_SWEEP_DWELL_EN
  logic [3:0] dwell_q, dwell_d, dcnt_q, dcnt_d, dwell_last;
`else
  logic unused_dwell;
  assign unused_dwell = ^dwell;
`endif
  assign rt = state_q == ISSUE;
  assign done = state_q == DONE;
  assign error = state_q == ERROR;
  assign busy = state_q inside {ISSUE, WAIT, SETTLE, STEP};
  assign count_quater_period = cqp_q;
  assign pass_count = pass_q;
  assign dir = dir_q;
  // 9-bit sums keep the clamp decisions free of 8-bit wraparound
  always_comb begin
    trig_edge = trig_q & ~trig_prev_q;
    sum9 = {1'b0, cur_q} + {1'b0, step_q};
    lo9 = {1'b0, min_q} + {1'b0, step_q};
    asc_nxt = (sum9 >= {1'b0, max_q}) ? max_q : sum9[7:0];
    desc_nxt = ({1'b0, cur_q} <= lo9) ? min_q : cur_q - step_q;
    at_end = dir_q ? (cur_q == min_q) : (cur_q == max_q);
`ifdef QPD_SWEEP_DWELL_EN
    dwell_last = (dwell_q == 4'd0) ? 4'd0 : dwell_q - 4'd1;
    dwell_d = dwell_q;
    dcnt_d = dcnt_q;
`endif
    state_d = state_q;
    min_d = min_q;
    max_d = max_q;
    step_d = step_q;
    npass_d = npass_q;
    cur_d = cur_q;
    pass_d = pass_q;
    dir_d = dir_q;
    tmo_d = tmo_q;
    set_d = set_q;
    if (stop && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start && !stop) begin
          state_d = LOAD;
          min_d = delay_min;
          max_d = delay_max;
          step_d = delay_step;
          npass_d = (n_passes == 8'd0) ? 8'd1 : n_passes;
`ifdef QPD_SWEEP_DWELL_EN
          dwell_d = dwell;
`endif
        end
        LOAD: if (step_q == 8'd0 || min_q > max_q) begin
          state_d = ERROR;
        end else begin
          state_d = ISSUE;
          cur_d = min_q;
          dir_d = 1'b0;
          pass_d = 8'd0;
`ifdef QPD_SWEEP_DWELL_EN
          dcnt_d = 4'd0;
`endif
        end
        ISSUE: begin
          state_d = WAIT;
          tmo_d = '0;
        end
        WAIT: if (trig_edge) begin
          state_d = SETTLE;
          set_d = '0;
        end else if (tmo_q == T_LAST) begin
          state_d = ERROR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
        SETTLE: if (set_q == S_LAST) begin
`ifdef QPD_SWEEP_DWELL_EN
          state_d = (dcnt_q != dwell_last) ? ISSUE : STEP;
          dcnt_d = (dcnt_q != dwell_last) ? dcnt_q + 4'd1 : 4'd0;
`else
          state_d = STEP;
`endif
        end else begin
          set_d = set_q + 1'b1;
        end
        // an endpoint closes its leg; the following point moves inward in the new direction
        STEP: if (at_end) begin
          pass_d = pass_q + 8'd1;
          dir_d = ~dir_q;
          state_d = (pass_q + 8'd1 == npass_q) ? DONE : ISSUE;
          cur_d = dir_q ? asc_nxt : desc_nxt;
        end else begin
          state_d = ISSUE;
          cur_d = dir_q ? desc_nxt : asc_nxt;
        end
        DONE: state_d = IDLE;
        ERROR: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    cqp_d = (state_d == ISSUE) ? cur_d : cqp_q;
  end
  always_ff @(posedge sclock) begin
    if (rst) begin
      state_q <= IDLE;
      min_q <= '0;
      max_q <= '0;
      step_q <= '0;
      npass_q <= '0;
      cur_q <= '0;
      cqp_q <= '0;
      pass_q <= '0;
      dir_q <= 1'b0;
      trig_q <= 1'b0;
      trig_prev_q <= 1'b0;
      tmo_q <= '0;
      set_q <= '0;
    end else begin
      state_q <= state_d;
      min_q <= min_d;
      max_q <= max_d;
      step_q <= step_d;
      npass_q <= npass_d;
      cur_q <= cur_d;
      cqp_q <= cqp_d;
      pass_q <= pass_d;
      dir_q <= dir_d;
      trig_q <= trigger_in;
      trig_prev_q <= trig_q;
      tmo_q <= tmo_d;
      set_q <= set_d;
    end
  end
`ifdef QPD_SWEEP_DWELL_EN
  always_ff @(posedge sclock) begin
    if (rst) begin
      dwell_q <= '0;
      dcnt_q <= '0;
    end else begin
      dwell_q <= dwell_d;
      dcnt_q <= dcnt_d;
    end
  end
`endif
endmodule

// File: tb/tb_qpd_sweep_ctrl.sv
// tb_qpd_sweep_ctrl: directed and random sweeps checked against a point-list model of the sweep rules.
module tb_qpd_sweep_ctrl;
  localparam int SETTLE = 16;
  localparam int TMO = 100;
  logic sclock = 0, rst = 1, start = 0, stop = 0, trigger_in = 0;
  logic [7:0] delay_min = 0, delay_max = 0, delay_step = 0, n_passes = 0;
  logic [3:0] dwell = 0;
  logic rt, busy, done, error, dir;
  logic [7:0] count_quater_period, pass_count;
  int n_chk = 0, n_fail = 0, done_n = 0, err_n = 0, cd = -1;
  bit trig_en = 1;
  logic [7:0] got[$], exp_q[$];

  qpd_sweep_ctrl #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
    .sclock(sclock), .rst(rst), .start(start), .stop(stop),
    .delay_min(delay_min), .delay_max(delay_max), .delay_step(delay_step),
    .n_passes(n_passes), .dwell(dwell), .trigger_in(trigger_in),
    .rt(rt), .count_quater_period(count_quater_period), .busy(busy),
    .done(done), .error(error), .pass_count(pass_count), .dir(dir)
  );

  always #5 sclock = ~sclock;

  // QPD stand-in: answers each rt with a one-cycle trigger three cycles later
  always @(negedge sclock) begin
    trigger_in = (cd == 0);
    cd = (cd > 0) ? cd - 1 : -1;
    if (rst) cd = -1;
    if (rt) begin
      got.push_back(count_quater_period);
      if (trig_en) cd = 2;
    end
    if (done) done_n++;
    if (error) err_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic void add(input int v, input int r);
    for (int i = 0; i < r; i++) exp_q.push_back(8'(v));
  endfunction

  function automatic void build_exp(input int mn, input int mx, input int st, input int np, input int dw);
    int ne, reps;
    exp_q.delete();
    ne = (np == 0) ? 1 : np;
    reps = 1;
`ifdef QPD_SWEEP_DWELL_EN
    reps = (dw == 0) ? 1 : dw;
`endif
    for (int leg = 0; leg < ne; leg++) begin
      if (leg == 0) add(mn, reps);
      if (mn == mx) begin
        if (leg > 0) add(mn, reps);
      end else if (leg % 2 == 0) begin
        for (int v = mn + st; v < mx; v += st) add(v, reps);
        add(mx, reps);
      end else begin
        for (int v = mx - st; v > mn; v -= st) add(v, reps);
        add(mn, reps);
      end
    end
  endfunction

  task automatic pulse_start();
    @(negedge sclock);
    start = 1;
    @(negedge sclock);
    start = 0;
  endtask

  task automatic set_cfg(input int mn, input int mx, input int st, input int np, input int dw);
    delay_min = 8'(mn);
    delay_max = 8'(mx);
    delay_step = 8'(st);
    n_passes = 8'(np);
    dwell = 4'(dw);
  endtask

  task automatic run_sweep(input int mn, input int mx, input int st, input int np, input int dw, input string tag);
    int ne, budget, k, bad, d0, e0;
    set_cfg(mn, mx, st, np, dw);
    trig_en = 1;
    build_exp(mn, mx, st, np, dw);
    ne = (np == 0) ? 1 : np;
    got.delete();
    d0 = done_n;
    e0 = err_n;
    pulse_start();
    set_cfg(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
    repeat (10) @(negedge sclock);
    start = 1;
    @(negedge sclock);
    start = 0;
    budget = 40 * exp_q.size() + 100;
    k = 0;
    while (done_n == d0 && err_n == e0 && k < budget) begin
      @(negedge sclock);
      k++;
    end
    repeat (2) @(negedge sclock);
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) if (got[i] !== exp_q[i]) bad++;
    chk({tag, "_done_pulses"}, done_n - d0, 1);
    chk({tag, "_error_pulses"}, err_n - e0, 0);
    chk({tag, "_n_points"}, got.size(), exp_q.size());
    chk({tag, "_bad_points"}, bad, 0);
    chk({tag, "_pass_count"}, pass_count, ne);
    chk({tag, "_dir"}, dir, ne % 2);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic run_bad(input int mn, input int mx, input int st, input string tag);
    int e0;
    set_cfg(mn, mx, st, 2, 1);
    got.delete();
    e0 = err_n;
    pulse_start();
    chk({tag, "_error_early"}, error, 0);
    @(negedge sclock);
    chk({tag, "_error_pulse"}, error, 1);
    chk({tag, "_busy"}, busy, 0);
    repeat (4) @(negedge sclock);
    chk({tag, "_error_count"}, err_n - e0, 1);
    chk({tag, "_no_rt"}, got.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rt"}, rt, 0);
    chk({tag, "_cqp"}, count_quater_period, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_pass"}, pass_count, 0);
    chk({tag, "_dir"}, dir, 0);
  endtask

  initial begin
    int t_rt, t_err, k, e0, d0, n0;
    repeat (3) @(negedge sclock);
    chk_zero("reset");
    rst = 0;
    repeat (2) @(negedge sclock);

    run_sweep(10, 40, 10, 2, 1, "t1");
    run_sweep(10, 35, 10, 1, 2, "t2");
    run_sweep(200, 255, 100, 3, 1, "wide");
    run_sweep(5, 5, 1, 2, 3, "single");
    run_sweep(0, 20, 7, 0, 2, "zero_passes");

    run_bad(10, 40, 0, "step0");
    run_bad(50, 20, 5, "min_gt_max");

    set_cfg(10, 40, 10, 1, 1);
    trig_en = 0;
    got.delete();
    e0 = err_n;
    t_rt = -1;
    t_err = -1;
    pulse_start();
    for (int i = 0; i < TMO + 50; i++) begin
      @(negedge sclock);
      if (rt && t_rt < 0) t_rt = i;
      if (error) begin
        t_err = i;
        break;
      end
    end
    chk("timeout_latency", t_err - t_rt, TMO + 1);
    chk("timeout_busy", busy, 0);
    @(negedge sclock);
    chk("timeout_points", got.size(), 1);
    chk("timeout_errors", err_n - e0, 1);
    trig_en = 1;

    set_cfg(10, 40, 10, 2, 1);
    got.delete();
    d0 = done_n;
    pulse_start();
    k = 0;
    for (int i = 0; i < 300 && k < 3; i++) begin
      @(negedge sclock);
      if (rt) k++;
    end
    repeat (10) @(negedge sclock);
    chk("stop_busy_before", busy, 1);
    stop = 1;
    @(negedge sclock);
    stop = 0;
    chk("stop_busy", busy, 0);
    chk("stop_rt", rt, 0);
    chk("stop_cqp", count_quater_period, 30);
    chk("stop_pass", pass_count, 0);
    repeat (40) @(negedge sclock);
    chk("stop_no_done", done_n - d0, 0);
    chk("stop_points", got.size(), 3);

    n0 = got.size();
    @(negedge sclock);
    start = 1;
    stop = 1;
    @(negedge sclock);
    start = 0;
    stop = 0;
    repeat (5) @(negedge sclock);
    chk("start_stop_busy", busy, 0);
    chk("start_stop_points", got.size(), n0);

    set_cfg(0, 100, 5, 2, 1);
    pulse_start();
    repeat (60) @(negedge sclock);
    chk("mid_busy", busy, 1);
    rst = 1;
    @(negedge sclock);
    chk_zero("mid_reset");
    rst = 0;
    repeat (5) @(negedge sclock);

    for (int r = 0; r < 8; r++) begin
      int mn, mx;
      mn = int'($urandom_range(0, 200));
      mx = mn + int'($urandom_range(0, 55));
      run_sweep(mn, mx, int'($urandom_range(5, 30)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
